// File: rtl/generate_proof_hls_deadlock_report_unit.sv
// Central deadlock controller for the HLS dataflow region. Collects the
// per-process deadlock flags, injects an origin pulse into one process,
// follows the report token around the dependency ring, kills the token and
// then streams the recorded process cycle out over a valid/ready port.
module generate_proof_hls_deadlock_report_unit #(
  parameter  int PROC_NUM    = 4,
  parameter  int TRACE_DEPTH = 8,
  parameter  int TIMEOUT_W   = 16,
  localparam int IDX_W       = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1,
  localparam int CNT_W       = $clog2(TRACE_DEPTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [PROC_NUM-1:0]  dl_detect_in,
  input  logic [PROC_NUM-1:0]  token_visit_vec,
  input  logic [TIMEOUT_W-1:0] cycle_budget,
  output logic [PROC_NUM-1:0]  origin,
  output logic                 token_clear,
  output logic                 dl_detect_out,
  output logic                 report_valid,
  input  logic                 report_ready,
  output logic [IDX_W-1:0]     report_proc,
  output logic                 report_last,
  output logic                 report_overflow,
  output logic                 timeout_err
);

  // Address width of the trace storage (may be narrower than the entry count)
  localparam int TR_W = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(TRACE_DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [PROC_NUM-1:0] ONE_HOT0 = {{(PROC_NUM-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, ARM, WALK, CLEAR, REPORT, DONE} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     org_q, org_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [TIMEOUT_W-1:0] budget_q, budget_d;
  logic [TIMEOUT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     rd_q, rd_d;
  logic                 overflow_q, overflow_d;
  logic                 timeout_q, timeout_d;
  logic [IDX_W-1:0]     trace_q [TRACE_DEPTH];
  logic [IDX_W-1:0]     trace_d [TRACE_DEPTH];

  logic [IDX_W-1:0]     det_idx;
  logic [IDX_W-1:0]     vis_idx;
  logic [TIMEOUT_W-1:0] timer_inc;
  logic                 loop_closed;

  // Priority pick: the lowest-numbered set bit wins
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [PROC_NUM-1:0] v);
    lowest_idx = '0;
    for (int i = PROC_NUM - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = IDX_W'(i);
    end
  endfunction

  // State and trace registers; reset aborts any walk without a token kill
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      org_q      <= '0;
      last_q     <= '0;
      budget_q   <= '0;
      timer_q    <= '0;
      cnt_q      <= '0;
      rd_q       <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      for (int i = 0; i < TRACE_DEPTH; i++) trace_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      org_q      <= org_d;
      last_q     <= last_d;
      budget_q   <= budget_d;
      timer_q    <= timer_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
      for (int i = 0; i < TRACE_DEPTH; i++) trace_q[i] <= trace_d[i];
    end
  end

  // Next-state logic: detection, token walk bookkeeping and report sequencing
  always_comb begin
    state_d     = state_q;
    org_d       = org_q;
    last_d      = last_q;
    budget_d    = budget_q;
    timer_d     = timer_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    overflow_d  = overflow_q;
    timeout_d   = timeout_q;
    trace_d     = trace_q;
    loop_closed = 1'b0;
    det_idx     = lowest_idx(dl_detect_in);
    vis_idx     = lowest_idx(token_visit_vec);
    timer_inc   = (timer_q == '1) ? timer_q : timer_q + TIMEOUT_W'(1);

    case (state_q)
      IDLE: begin
        if (|dl_detect_in) begin
          org_d      = det_idx;
          last_d     = det_idx;
          budget_d   = cycle_budget;
          trace_d[0] = det_idx;
          cnt_d      = ONE_C;
          timer_d    = '0;
          state_d    = ARM;
        end
      end
      ARM: state_d = WALK;
      WALK: begin
        timer_d = timer_inc;
        if (|token_visit_vec) begin
          if (vis_idx == org_q) begin
            loop_closed = 1'b1;
            state_d     = CLEAR;
          end else if (vis_idx != last_q) begin
            if (cnt_q < DEPTH_C) begin
              trace_d[cnt_q[TR_W-1:0]] = vis_idx;
              cnt_d = cnt_q + ONE_C;
            end else begin
              overflow_d = 1'b1;
            end
            last_d = vis_idx;
          end
        end
        if (!loop_closed && (budget_q != '0) && (timer_inc == budget_q)) begin
          timeout_d = 1'b1;
          state_d   = CLEAR;
        end
      end
      CLEAR: begin
        rd_d    = '0;
        state_d = REPORT;
      end
      REPORT: begin
        if (report_ready) begin
          if (rd_q == cnt_q - ONE_C) state_d = DONE;
          else                       rd_d    = rd_q + ONE_C;
        end
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from registered state only
  always_comb begin
    origin          = (state_q == ARM) ? (ONE_HOT0 << org_q) : '0;
    token_clear     = (state_q == CLEAR);
    dl_detect_out   = (state_q != IDLE);
    report_valid    = (state_q == REPORT);
    report_proc     = (state_q == REPORT) ? trace_q[rd_q[TR_W-1:0]] : '0;
    report_last     = (state_q == REPORT) && (rd_q == cnt_q - ONE_C);
    report_overflow = overflow_q;
    timeout_err     = timeout_q;
  end

endmodule

// File: tb/tb_generate_proof_hls_deadlock_report_unit.sv
// Self-checking bench: two instances (trace depth 8 and 2) share all inputs;
// expectations come from a behavioural model of the token walk.
module tb_generate_proof_hls_deadlock_report_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] dl_detect_in;
  logic [3:0] token_visit_vec;
  logic [15:0] cycle_budget;
  logic       report_ready;

  logic [3:0] origin_a, origin_b;
  logic       token_clear_a, token_clear_b;
  logic       dl_detect_out_a, dl_detect_out_b;
  logic       report_valid_a, report_valid_b;
  logic [1:0] report_proc_a, report_proc_b;
  logic       report_last_a, report_last_b;
  logic       report_overflow_a, report_overflow_b;
  logic       timeout_err_a, timeout_err_b;

  int total = 0;
  int bad = 0;
  int clr_cnt_a = 0;
  int org_cnt_a = 0;

  logic [3:0] visits_q[$];
  int         exp_trace[$];
  int         exp_len;
  bit         exp_to;

  generate_proof_hls_deadlock_report_unit #(.PROC_NUM(4), .TRACE_DEPTH(8), .TIMEOUT_W(16)) dut_a (
    .clock(clock), .reset(reset), .dl_detect_in(dl_detect_in), .token_visit_vec(token_visit_vec),
    .cycle_budget(cycle_budget), .origin(origin_a), .token_clear(token_clear_a),
    .dl_detect_out(dl_detect_out_a), .report_valid(report_valid_a), .report_ready(report_ready),
    .report_proc(report_proc_a), .report_last(report_last_a),
    .report_overflow(report_overflow_a), .timeout_err(timeout_err_a));

  generate_proof_hls_deadlock_report_unit #(.PROC_NUM(4), .TRACE_DEPTH(2), .TIMEOUT_W(16)) dut_b (
    .clock(clock), .reset(reset), .dl_detect_in(dl_detect_in), .token_visit_vec(token_visit_vec),
    .cycle_budget(cycle_budget), .origin(origin_b), .token_clear(token_clear_b),
    .dl_detect_out(dl_detect_out_b), .report_valid(report_valid_b), .report_ready(report_ready),
    .report_proc(report_proc_b), .report_last(report_last_b),
    .report_overflow(report_overflow_b), .timeout_err(timeout_err_b));

  // Free-running clock
  always #5 clock = ~clock;

  // Pulse counters sampled mid-cycle
  always @(negedge clock) begin
    if (token_clear_a) clr_cnt_a++;
    if (origin_a != 4'b0000) org_cnt_a++;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference: walk the visit list, record distinct consecutive processes
  // until the origin is seen again or the cycle budget runs out.
  task automatic compute_model(input int org, input int budget);
    int last;
    int p;
    logic [3:0] v;
    exp_trace = {};
    exp_trace.push_back(org);
    last = org;
    exp_to = 1'b0;
    exp_len = 0;
    for (int k = 1; k <= 1000; k++) begin
      v = (k <= visits_q.size()) ? visits_q[k-1] : 4'b0000;
      p = lowest(v);
      if (p == org) begin
        exp_len = k;
        break;
      end
      if (p >= 0 && p != last) begin
        exp_trace.push_back(p);
        last = p;
      end
      if (budget != 0 && k == budget) begin
        exp_to = 1'b1;
        exp_len = k;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dl_detect_in = 4'b0000;
    token_visit_vec = 4'b0000;
    report_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    clr_cnt_a = 0;
    org_cnt_a = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cycle_budget = 16'd0;
    dl_detect_in = 4'b1111;
    step();
    total++;
    if (origin_a !== 4'b0001 || dl_detect_out_a !== 1'b1)
      begin bad++; $display("[TB] FAIL reset_arm: origin=%b dl=%b want 0001/1", origin_a, dl_detect_out_a); end
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({origin_a, token_clear_a, dl_detect_out_a, report_valid_a, report_proc_a, report_last_a,
         report_overflow_a, timeout_err_a} !== 11'd0)
      begin bad++; $display("[TB] FAIL async_reset_a: outputs not all zero (dl=%b org=%b)", dl_detect_out_a, origin_a); end
    total++;
    if ({origin_b, token_clear_b, dl_detect_out_b, report_valid_b, report_proc_b, report_last_b,
         report_overflow_b, timeout_err_b} !== 11'd0)
      begin bad++; $display("[TB] FAIL async_reset_b: outputs not all zero (dl=%b org=%b)", dl_detect_out_b, origin_b); end
    step();
    step();
    dl_detect_in = 4'b0000;
    reset = 1'b0;
    step();
    total++;
    if (dl_detect_out_a !== 1'b0 || token_clear_a !== 1'b0 || clr_cnt_a !== 0)
      begin bad++; $display("[TB] FAIL reset_idle: dl=%b clr=%0d want 0/0", dl_detect_out_a, clr_cnt_a); end
    clr_cnt_a = 0;
    org_cnt_a = 0;
  endtask

  // mode 0: ready always high, 1: random ready, 2: ready low for 3 cycles first
  task automatic run_case(input string name, input logic [3:0] dl, input int budget, input int mode);
    int org, na, nb, cyc, done_cyc_a;
    int got_a[$];
    int got_b[$];
    bit done_a, done_b, pv_a, pv_b, pr;
    logic [1:0] pp_a, pp_b;
    logic pl_a, pl_b;
    org = lowest(dl);
    compute_model(org, budget);
    na = (exp_trace.size() > 8) ? 8 : exp_trace.size();
    nb = (exp_trace.size() > 2) ? 2 : exp_trace.size();

    cycle_budget = 16'(budget);
    dl_detect_in = dl;
    token_visit_vec = 4'b0000;
    step();
    total++;
    if (origin_a !== (4'b0001 << org) || origin_b !== (4'b0001 << org) || dl_detect_out_a !== 1'b1)
      begin bad++; $display("[TB] FAIL %s origin: got %b/%b dl=%b want %b/1", name, origin_a, origin_b, dl_detect_out_a, 4'b0001 << org); end
    dl_detect_in = 4'($urandom_range(0, 15));
    cycle_budget = 16'($urandom_range(1, 3));
    step();
    for (int k = 1; k <= exp_len; k++) begin
      token_visit_vec = (k <= visits_q.size()) ? visits_q[k-1] : 4'b0000;
      total++;
      if (origin_a !== 4'b0000 || token_clear_a !== 1'b0 || dl_detect_out_a !== 1'b1)
        begin bad++; $display("[TB] FAIL %s walk%0d: origin=%b clr=%b dl=%b want 0000/0/1", name, k, origin_a, token_clear_a, dl_detect_out_a); end
      step();
    end
    total++;
    if (token_clear_a !== 1'b1 || token_clear_b !== 1'b1)
      begin bad++; $display("[TB] FAIL %s clear: got %b/%b want 1", name, token_clear_a, token_clear_b); end
    total++;
    if (timeout_err_a !== exp_to || timeout_err_b !== exp_to)
      begin bad++; $display("[TB] FAIL %s timeout: got %b/%b want %b", name, timeout_err_a, timeout_err_b, exp_to); end
    token_visit_vec = 4'($urandom_range(0, 15));
    step();

    cyc = 0; done_a = 0; done_b = 0; pv_a = 0; pv_b = 0; pr = 0; done_cyc_a = -1;
    pp_a = '0; pp_b = '0; pl_a = 0; pl_b = 0;
    while (!(done_a && done_b) && cyc < 300) begin
      report_ready = (mode == 0) ? 1'b1 : (mode == 2) ? (cyc >= 3) : 1'($urandom_range(0, 1));
      if (!done_a) begin
        total++;
        if (report_valid_a !== 1'b1)
          begin bad++; $display("[TB] FAIL %s valid_a: got %b want 1", name, report_valid_a); end
        if (pv_a && !pr) begin
          total++;
          if (report_proc_a !== pp_a || report_last_a !== pl_a)
            begin bad++; $display("[TB] FAIL %s hold_a: got %0d/%b want %0d/%b", name, report_proc_a, report_last_a, pp_a, pl_a); end
        end
        if (report_ready) begin
          got_a.push_back(int'(report_proc_a));
          total++;
          if (report_last_a !== (got_a.size() == na))
            begin bad++; $display("[TB] FAIL %s last_a: entry %0d got %b want %b", name, got_a.size(), report_last_a, got_a.size() == na); end
          if (report_last_a) begin done_a = 1; done_cyc_a = cyc + 1; end
        end
      end
      if (!done_b) begin
        if (pv_b && !pr) begin
          total++;
          if (report_proc_b !== pp_b || report_last_b !== pl_b)
            begin bad++; $display("[TB] FAIL %s hold_b: got %0d/%b want %0d/%b", name, report_proc_b, report_last_b, pp_b, pl_b); end
        end
        if (report_ready && report_valid_b) begin
          got_b.push_back(int'(report_proc_b));
          total++;
          if (report_last_b !== (got_b.size() == nb))
            begin bad++; $display("[TB] FAIL %s last_b: entry %0d got %b want %b", name, got_b.size(), report_last_b, got_b.size() == nb); end
          if (report_last_b) done_b = 1;
        end
      end
      pv_a = report_valid_a; pp_a = report_proc_a; pl_a = report_last_a;
      pv_b = report_valid_b; pp_b = report_proc_b; pl_b = report_last_b;
      pr = report_ready;
      step();
      cyc++;
    end
    report_ready = 1'b0;
    total++;
    if (!(done_a && done_b))
      begin bad++; $display("[TB] FAIL %s report_bound: done=%b/%b want 1/1", name, done_a, done_b); end

    total++;
    if (got_a.size() != na)
      begin bad++; $display("[TB] FAIL %s count_a: got %0d want %0d", name, got_a.size(), na); end
    for (int i = 0; i < na && i < got_a.size(); i++) begin
      total++;
      if (got_a[i] != exp_trace[i])
        begin bad++; $display("[TB] FAIL %s entry_a[%0d]: got %0d want %0d", name, i, got_a[i], exp_trace[i]); end
    end
    total++;
    if (got_b.size() != nb)
      begin bad++; $display("[TB] FAIL %s count_b: got %0d want %0d", name, got_b.size(), nb); end
    for (int i = 0; i < nb && i < got_b.size(); i++) begin
      total++;
      if (got_b[i] != exp_trace[i])
        begin bad++; $display("[TB] FAIL %s entry_b[%0d]: got %0d want %0d", name, i, got_b[i], exp_trace[i]); end
    end
    if (mode == 0) begin
      total++;
      if (done_cyc_a != na)
        begin bad++; $display("[TB] FAIL %s throughput: got %0d cycles want %0d", name, done_cyc_a, na); end
    end

    dl_detect_in = 4'($urandom_range(1, 15));
    report_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (report_valid_a !== 1'b0 || report_valid_b !== 1'b0 || dl_detect_out_a !== 1'b1 || dl_detect_out_b !== 1'b1 ||
          origin_a !== 4'b0000 || token_clear_a !== 1'b0)
        begin bad++; $display("[TB] FAIL %s done_hold: valid=%b/%b dl=%b/%b org=%b want 0/0 1/1 0000", name,
          report_valid_a, report_valid_b, dl_detect_out_a, dl_detect_out_b, origin_a); end
      total++;
      if (report_overflow_a !== (exp_trace.size() > 8) || report_overflow_b !== (exp_trace.size() > 2) ||
          timeout_err_a !== exp_to || timeout_err_b !== exp_to)
        begin bad++; $display("[TB] FAIL %s sticky: ovf=%b/%b to=%b/%b want %b/%b %b", name, report_overflow_a,
          report_overflow_b, timeout_err_a, timeout_err_b, exp_trace.size() > 8, exp_trace.size() > 2, exp_to); end
      step();
    end
    total++;
    if (clr_cnt_a != 1 || org_cnt_a != 1)
      begin bad++; $display("[TB] FAIL %s pulses: clear=%0d origin=%0d want 1/1", name, clr_cnt_a, org_cnt_a); end
    do_reset();
  endtask

  task automatic test_basic_loop();
    visits_q = {4'b0001, 4'b0001, 4'b1000, 4'b0100};
    run_case("basic", 4'b0100, 0, 0);
  endtask

  task automatic test_simultaneous();
    visits_q = {4'b0100, 4'b0010};
    run_case("simul", 4'b1010, 0, 0);
  endtask

  task automatic test_timeout();
    visits_q = {4'b0001};
    run_case("timeout", 4'b0100, 5, 0);
  endtask

  task automatic test_backpressure();
    visits_q = {4'b0001, 4'b0001, 4'b1000, 4'b0100};
    run_case("backpressure", 4'b0100, 0, 2);
  endtask

  task automatic test_overflow();
    visits_q = {4'b0010, 4'b0100, 4'b1000, 4'b0001};
    run_case("overflow_small", 4'b0001, 0, 0);
    visits_q = {};
    for (int i = 0; i < 5; i++) begin
      visits_q.push_back(4'b0010);
      visits_q.push_back(4'b1100);
    end
    visits_q.push_back(4'b0001);
    run_case("overflow_long", 4'b0001, 0, 1);
  endtask

  task automatic test_random();
    logic [3:0] dl;
    int budget, n;
    for (int t = 0; t < 25; t++) begin
      dl = 4'($urandom_range(1, 15));
      budget = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 12);
      n = $urandom_range(0, 12);
      visits_q = {};
      for (int i = 0; i < n; i++)
        visits_q.push_back(($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(1, 15)));
      visits_q.push_back(4'b0001 << lowest(dl));
      run_case("random", dl, budget, 1);
    end
  endtask

  initial begin
    reset = 1'b1;
    dl_detect_in = 4'b0000;
    token_visit_vec = 4'b0000;
    cycle_budget = 16'd0;
    report_ready = 1'b0;
    do_reset();
    test_reset();
    test_basic_loop();
    test_simultaneous();
    test_timeout();
    test_backpressure();
    test_overflow();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
